pipe_hazard_scoreboard: RTL
===========================

Name: pipe_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the ID stage of the pipelined CPU.
- Tracks the destination register of every in-flight instruction across DEPTH post-ID stages (EX, MEM, WB, ...) in a shadow shift register.
- Drives the load-use stall and per-operand forwarding selects, and kills younger instructions on a taken jump.
- Replaces fixed EX/MEM-only stall logic; counts stall cycles for performance measurement.

Parameters:
- DEPTH, 3, number of tracked stages after ID; index 0 = EX, 1 = MEM, 2 = WB.
- REG_AW, 5, register-number width; register 0 is hard-wired zero.
- LOAD_LAT, 1, lowest stage index at which a load result is forwardable; range 0..DEPTH-1.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register A.
- id_rt  in  REG_AW  source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes the register file.
- id_m2reg  in  1  instruction is a load.
- id_wn  in  REG_AW  destination register.
- flush  in  1  taken jump resolved in MEM; kills the ID and EX instructions.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall  out  1  hold PC and IF/ID register; insert a bubble into EX.
- fwd_a  out  $clog2(DEPTH+1)  operand A source: 0 = regfile, k+1 = stage k result.
- fwd_b  out  $clog2(DEPTH+1)  operand B source, same encoding as fwd_a.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow entry per stage k: valid, wreg, m2reg, wn.
- Reset: all entries cleared (valid=0); stall_cnt=0. After reset: stall=0, fwd_a=0, fwd_b=0.
- Match on stage k for operand rs: valid[k] & wreg[k] & wn[k]==id_rs & id_rs!=0 & id_use_rs & id_valid. Operand rt uses the same rule with id_rt and id_use_rt.
- Priority: the youngest (lowest k) matching stage wins.
  - Winner is a load with k<LOAD_LAT: operand is not ready; raise stall; the fwd value is don't-care but driven as 0.
  - Any other winner: fwd = k+1.
  - No match: fwd = 0.
- stall = (operand A not ready | operand B not ready) & ~flush. stall, fwd_a and fwd_b are combinational from current state; zero latency.
- Every rising edge, entries k=1..DEPTH-1 load from entry k-1. Entry DEPTH-1 retires.
- Entry 0 loads from ID with valid = id_valid & ~stall & ~flush. When not valid, entry 0 is a bubble (valid=0).
- flush also clears entry 0 before the shift, so stage 1 receives a bubble. Older entries are unaffected.
- flush and stall in the same cycle: flush wins, stall=0, and no stall is counted.
- stall_cnt increments on each cycle with stall=1. It saturates at all-ones. cnt_clr has priority over increment.
- Writes to register 0 never match, even when wreg=1.
- Default latency (LOAD_LAT=1, DEPTH=3): a dependent instruction directly after a load stalls 1 cycle, then forwards from MEM (code 2). Any ALU result forwards from EX with no stall.
- Reset asserted mid-operation clears all entries at once; nothing in flight is replayed.

Decomposition:
- Shared pipeline package holds:
  - forwarding-code constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3;
  - REG_AW;
  - a stage-entry struct (valid, wreg, m2reg, wn).
- One natural sub-module, pipe_fwd_match: a combinational priority search for one operand. It is instantiated twice, for rs and rt.

Test Plan:
- Reset with clrn=0, then release → stall=0, fwd_a=0, fwd_b=0, stall_cnt=0; an instruction reading r3 gets fwd_a=0.
- ALU write r5, then next instruction reads r5 as rs → fwd_a=1 (EX). One cycle later, an instruction reading r5 as rt → fwd_b=2 (MEM).
- Load r7, then add using r7 → stall=1 for exactly 1 cycle; next cycle fwd_a=2, stall=0, stall_cnt=1.
- Writes to r9 from EX and MEM both valid, reader of r9 → fwd_a=1 (youngest wins). Write to r0 followed by a reader of r0 → fwd_a=0, no stall.
- Load r4 in EX with flush=1 and ID reading r4 → stall=0; next cycle stage 1 is a bubble and stall_cnt is unchanged.
- Force CNT_W=4 and hold a load-use hazard for 20 cycles → stall_cnt saturates at 15; cnt_clr=1 → 0 on the next edge.

Source files
------------

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/forwarding unit.
//   REG_AW        register-number width (register 0 is hard-wired zero)
//   FWD_*         operand-source codes driven on fwd_a / fwd_b
//   stage_entry_t shadow copy of one in-flight instruction's write-back info
package pipe_hazard_scoreboard_pkg;

  localparam int REG_AW = 5;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic [REG_AW-1:0] wn;
  } stage_entry_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_fwd_match.sv
// pipe_fwd_match: combinational priority search for one source operand.
// Finds the youngest in-flight stage that writes the operand's register and
// reports either a forwarding code (k+1) or that the value is not yet ready
// (a load that has not reached LOAD_LAT).
//   i_stage      shadow entries, index 0 = EX (youngest)
//   i_id_valid   ID holds a real instruction
//   i_use        instruction actually reads this operand
//   i_src        operand register number
//   o_fwd        0 = regfile, k+1 = stage k result
//   o_not_ready  youngest producer is a load whose data is not forwardable yet
module pipe_fwd_match
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FW       = $clog2(DEPTH + 1)
) (
  input  stage_entry_t [DEPTH-1:0] i_stage,
  input  logic                     i_id_valid,
  input  logic                     i_use,
  input  logic [REG_AW-1:0]        i_src,
  output logic [FW-1:0]            o_fwd,
  output logic                     o_not_ready
);

  logic w_read;

  assign w_read = i_id_valid & i_use & (i_src != '0);

  // Walk from oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    o_fwd       = FW'(FWD_RF);
    o_not_ready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_read && i_stage[k].valid && i_stage[k].wreg && (i_stage[k].wn == i_src)) begin
        if (i_stage[k].m2reg && (k < LOAD_LAT)) begin
          o_fwd       = FW'(FWD_RF);
          o_not_ready = 1'b1;
        end else begin
          o_fwd       = FW'(k + 1);
          o_not_ready = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: ID-stage hazard and forwarding unit.
// Keeps a shadow shift register of destination info for DEPTH post-ID stages,
// drives load-use stall and per-operand forwarding selects, kills the ID/EX
// instructions on a taken jump and counts stall cycles (saturating).
//   clk, clrn                      clock / async active-low reset
//   id_valid, id_rs, id_rt         ID instruction and its source registers
//   id_use_rs, id_use_rt           which sources are actually read
//   id_wreg, id_m2reg, id_wn       ID instruction's write-back info
//   flush                          taken jump resolved in MEM
//   cnt_clr                        synchronous clear of stall_cnt
//   stall                          hold PC / IF-ID, bubble into EX
//   fwd_a, fwd_b                   operand sources (0 = regfile, k+1 = stage k)
//   stall_cnt                      saturating stall-cycle count
module pipe_hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = pipe_hazard_scoreboard_pkg::REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int FW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [REG_AW-1:0] id_wn,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_hazard_scoreboard_pkg::*;

  stage_entry_t [DEPTH-1:0] r_stage;
  stage_entry_t             w_entry_in;
  logic [CNT_W-1:0]         r_stall_cnt;
  logic                     w_nr_a;
  logic                     w_nr_b;
  logic                     w_issue;

  pipe_fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .FW       (FW)
  ) u_match_rs (
    .i_stage     (r_stage),
    .i_id_valid  (id_valid),
    .i_use       (id_use_rs),
    .i_src       (id_rs),
    .o_fwd       (fwd_a),
    .o_not_ready (w_nr_a)
  );

  pipe_fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .FW       (FW)
  ) u_match_rt (
    .i_stage     (r_stage),
    .i_id_valid  (id_valid),
    .i_use       (id_use_rt),
    .i_src       (id_rt),
    .o_fwd       (fwd_b),
    .o_not_ready (w_nr_b)
  );

  // A flush kills the ID instruction, so it can never be waiting on anything.
  assign stall   = (w_nr_a | w_nr_b) & ~flush;
  assign w_issue = id_valid & ~stall & ~flush;

  // Non-issuing cycles put a fully zeroed bubble into EX.
  always_comb begin
    w_entry_in = '0;
    if (w_issue) begin
      w_entry_in.valid = 1'b1;
      w_entry_in.wreg  = id_wreg;
      w_entry_in.m2reg = id_m2reg;
      w_entry_in.wn    = id_wn;
    end
  end

  // On flush the EX instruction is killed on its way into MEM; older
  // stages shift normally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stage <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_stage[k] <= ((k == 1) && flush) ? '0 : r_stage[k-1];
      end
      r_stage[0] <= w_entry_in;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
